// File: rtl/score_digit_sequencer.sv
// score_digit_sequencer: six-digit BCD score counter for the on-screen number
// renderer. Arbitrates distance ticks and bonus pickups, ripples BCD carries
// one digit per clock and presents a tear-free snapshot latched at frame start.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module score_digit_sequencer #(
    parameter int BONUS_POS = 2,
    parameter int PEND_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       clearScore,
    input  logic       distTick,
    input  logic       bonusReq,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] digit5,
    output logic [3:0] digit6,
    output logic [5:0] digitVisible,
    output logic       busy,
    output logic       saturated,
    output logic       pendOverflow
);

    typedef enum logic {IDLE, RIPPLE} state_t;

    localparam logic [2:0]        BONUS_IDX = 3'(BONUS_POS);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    state_t            state, state_nx;
    logic [5:0][3:0]   work, work_nx, disp;
    logic [2:0]        pos, pos_nx, step_pos;
    logic              step_en, do_sat, svc_bonus, svc_dist;
    logic [PEND_W-1:0] pend_dist, pend_dist_nx, pend_bonus, pend_bonus_nx;
    logic              dist_drop, bonus_drop;
    logic              sat_r, ovf_r, snap_pend, take_snap;

    // Next-state logic: pick a requester in IDLE, apply one BCD digit step per cycle
    always_comb begin
        svc_bonus = 1'b0;
        svc_dist  = 1'b0;
        step_en   = 1'b0;
        step_pos  = pos;
        do_sat    = 1'b0;
        state_nx  = state;
        pos_nx    = pos;
        work_nx   = work;
        unique case (state)
            IDLE: begin
                if (pend_bonus != '0) begin
                    svc_bonus = 1'b1;
                    step_pos  = BONUS_IDX;
                end else if (pend_dist != '0) begin
                    svc_dist = 1'b1;
                    step_pos = 3'd0;
                end
                // once saturated, requests are consumed without touching the score
                step_en = (svc_bonus || svc_dist) && !sat_r;
            end
            RIPPLE: begin
                step_en = 1'b1;
            end
        endcase
        if (step_en) begin
            if (work[step_pos] < 4'd9) begin
                work_nx[step_pos] = work[step_pos] + 4'd1;
                state_nx          = IDLE;
            end else begin
                work_nx[step_pos] = '0;
                if (step_pos == 3'd5) begin
                    do_sat = 1'b1;
                end else begin
                    state_nx = RIPPLE;
                    pos_nx   = step_pos + 3'd1;
                end
            end
        end
        if (do_sat) begin
            work_nx  = {6{4'd9}};
            state_nx = IDLE;
        end
    end

    // Pending request counters: pulse and service in the same cycle cancel out
    always_comb begin
        pend_dist_nx  = pend_dist;
        pend_bonus_nx = pend_bonus;
        dist_drop     = 1'b0;
        bonus_drop    = 1'b0;
        if (distTick && !svc_dist) begin
            if (&pend_dist) dist_drop = 1'b1;
            else            pend_dist_nx = pend_dist + PEND_ONE;
        end else if (!distTick && svc_dist) begin
            pend_dist_nx = pend_dist - PEND_ONE;
        end
        if (bonusReq && !svc_bonus) begin
            if (&pend_bonus) bonus_drop = 1'b1;
            else             pend_bonus_nx = pend_bonus + PEND_ONE;
        end else if (!bonusReq && svc_bonus) begin
            pend_bonus_nx = pend_bonus - PEND_ONE;
        end
    end

    // The working score is only consistent in IDLE, so snapshots wait for it
    assign take_snap = (state == IDLE) && (startOfFrame || snap_pend);

    // State, score, counters, flags and display snapshot registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pos        <= '0;
            work       <= '0;
            disp       <= '0;
            pend_dist  <= '0;
            pend_bonus <= '0;
            sat_r      <= 1'b0;
            ovf_r      <= 1'b0;
            snap_pend  <= 1'b0;
        end else if (clearScore) begin
            state      <= IDLE;
            pos        <= '0;
            work       <= '0;
            disp       <= '0;
            pend_dist  <= '0;
            pend_bonus <= '0;
            sat_r      <= 1'b0;
            ovf_r      <= 1'b0;
            snap_pend  <= 1'b0;
        end else begin
            state      <= state_nx;
            pos        <= pos_nx;
            work       <= work_nx;
            pend_dist  <= pend_dist_nx;
            pend_bonus <= pend_bonus_nx;
            if (do_sat) sat_r <= 1'b1;
            if (dist_drop || bonus_drop) ovf_r <= 1'b1;
            if (take_snap) begin
                disp      <= work;
                snap_pend <= 1'b0;
            end else if (startOfFrame) begin
                snap_pend <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [5:0] vis_of(input logic [5:0][3:0] d);
        logic [5:0] v;
        logic       seen;
        v    = 6'b000001;
        seen = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (d[5-i] != 4'd0) seen = 1'b1;
            v[5-i] = seen;
        end
        return v;
    endfunction

    logic [5:0] vis_r;

    // Visibility mask follows the snapshot on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           vis_r <= 6'b000001;
        else if (clearScore) vis_r <= 6'b000001;
        else if (take_snap)  vis_r <= vis_of(work);
    end

    assign digitVisible = vis_r;
`else
    assign digitVisible = '1;
`endif

    assign digit1       = disp[5];
    assign digit2       = disp[4];
    assign digit3       = disp[3];
    assign digit4       = disp[2];
    assign digit5       = disp[1];
    assign digit6       = disp[0];
    assign busy         = (state == RIPPLE);
    assign saturated    = sat_r;
    assign pendOverflow = ovf_r;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Testbench for score_digit_sequencer: table of cumulative score vectors plus
// hand-written sequences for ripple timing, arbitration, overflow, reset and
// saturation. Honours LEADING_ZERO_BLANK_EN for the expected visibility mask.
module tb_score_digit_sequencer;

    logic       clk = 1'b0;
    logic       reset, startOfFrame, clearScore, distTick, bonusReq;
    logic [3:0] digit1, digit2, digit3, digit4, digit5, digit6;
    logic [5:0] digitVisible;
    logic       busy, saturated, pendOverflow;
    logic [23:0] disp;

    int checks = 0;
    int passed = 0;
    bit done_drv;

    score_digit_sequencer #(.BONUS_POS(2), .PEND_W(4)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .clearScore(clearScore), .distTick(distTick), .bonusReq(bonusReq),
        .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .digit4(digit4), .digit5(digit5), .digit6(digit6),
        .digitVisible(digitVisible), .busy(busy),
        .saturated(saturated), .pendOverflow(pendOverflow)
    );

    assign disp = {digit1, digit2, digit3, digit4, digit5, digit6};

    always #5 clk = ~clk;

    typedef struct {
        bit          clr;
        int          nb;
        int          nd;
        logic [23:0] exp;
    } vec_t;

    function automatic logic [5:0] exp_vis(input logic [23:0] v);
        logic [5:0] r;
        logic       seen;
        r    = 6'b000001;
        seen = 1'b0;
        for (int i = 5; i >= 1; i--) begin
            if (v[i*4 +: 4] != 4'd0) seen = 1'b1;
            r[i] = seen;
        end
`ifndef LEADING_ZERO_BLANK_EN
        r = 6'b111111;
`endif
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [23:0] v);
        for (int i = 0; i < 6; i++)
            if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clearScore = 1'b1;
        step();
        clearScore = 1'b0;
        step();
    endtask

    // Pulses spaced two cycles apart, then enough idle time to drain
    task automatic run(input int nb, input int nd);
        for (int i = 0; i < nb; i++) begin
            bonusReq = 1'b1; step(); bonusReq = 1'b0; step();
        end
        for (int i = 0; i < nd; i++) begin
            distTick = 1'b1; step(); distTick = 1'b0; step();
        end
        repeat (30) step();
    endtask

    task automatic snap();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        logic [23:0] prev, cur, d6, d7;
        int          busycnt;

        vecs[0] = '{1'b1, 0,  0,  24'h000000};
        vecs[1] = '{1'b0, 0,  9,  24'h000009};
        vecs[2] = '{1'b0, 0,  1,  24'h000010};
        vecs[3] = '{1'b0, 9,  0,  24'h000910};
        vecs[4] = '{1'b0, 1,  0,  24'h001010};
        vecs[5] = '{1'b0, 0,  90, 24'h001100};
        vecs[6] = '{1'b1, 0,  5,  24'h000005};
        vecs[7] = '{1'b0, 99, 94, 24'h009999};

        reset = 1'b1; startOfFrame = 1'b0; clearScore = 1'b0;
        distTick = 1'b0; bonusReq = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_digits", disp, 24'h000000);
        chk("rst_vis", digitVisible, exp_vis(24'h000000));
        chk("rst_busy", busy, 0);
        chk("rst_sat", saturated, 0);
        chk("rst_ovf", pendOverflow, 0);

        // Table of cumulative score updates
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].clr) do_clear();
            run(vecs[i].nb, vecs[i].nd);
            snap();
            chk($sformatf("vec%0d_digits", i), disp, vecs[i].exp);
            chk($sformatf("vec%0d_vis", i), digitVisible, exp_vis(vecs[i].exp));
            chk($sformatf("vec%0d_sat", i), saturated, 0);
        end

        // Snapshots taken during a stream of updates stay valid and monotonic
        do_clear();
        done_drv = 1'b0;
        prev = '0;
        fork
            begin
                for (int i = 0; i < 99; i++) begin
                    bonusReq = 1'b1; step(); bonusReq = 1'b0; repeat (3) step();
                end
                for (int i = 0; i < 99; i++) begin
                    distTick = 1'b1; step(); distTick = 1'b0; repeat (3) step();
                end
                done_drv = 1'b1;
            end
            begin
                while (!done_drv) begin
                    repeat (55) step();
                    snap();
                    cur = disp;
                    chk("mono_bcd", bcd_ok(cur), 1);
                    chk("mono_order", (cur >= prev), 1);
                    prev = cur;
                end
            end
        join
        repeat (30) step();
        snap();
        chk("stream_final", disp, 24'h009999);

        // Reset during the second ripple cycle of 009999 -> 010000
        distTick = 1'b1; step(); distTick = 1'b0;
        step();
        chk("mid_ripple_busy", busy, 1);
        step();
        reset = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_digits", disp, 24'h000000);
        chk("async_rst_vis", digitVisible, exp_vis(24'h000000));
        chk("async_rst_flags", {saturated, pendOverflow}, 0);
        step();
        reset = 1'b0;
        step();
        snap();
        chk("post_rst_score", disp, 24'h000000);

        // Simultaneous requests: bonus is served one cycle before distance
        distTick = 1'b1; bonusReq = 1'b1; step();
        distTick = 1'b0; bonusReq = 1'b0;
        step();
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        chk("arb_bonus_first", disp, 24'h000100);
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        chk("arb_then_dist", disp, 24'h000101);

        // Distance starves behind a continuous bonus stream and overflows
        do_clear();
        for (int i = 0; i < 20; i++) begin
            distTick = 1'b1; bonusReq = 1'b1; step();
            if (i == 14) chk("ovf_not_yet", pendOverflow, 0);
        end
        distTick = 1'b0; bonusReq = 1'b0;
        repeat (40) step();
        chk("ovf_flag", pendOverflow, 1);
        snap();
        chk("ovf_score", disp, 24'h002015);

        // Longest ripple 099999 -> 100000 with a deferred snapshot
        do_clear();
        run(999, 99);
        snap();
        chk("pre_long_ripple", disp, 24'h099999);
        distTick = 1'b1; step(); distTick = 1'b0;
        busycnt = 0;
        d6 = '0;
        d7 = '0;
        for (int k = 1; k <= 8; k++) begin
            startOfFrame = (k == 2);
            step();
            startOfFrame = 1'b0;
            if (busy) busycnt++;
            if (k == 6) d6 = disp;
            if (k == 7) d7 = disp;
        end
        chk("long_busy_cycles", busycnt, 5);
        chk("snap_deferred", d6, 24'h099999);
        chk("snap_after_idle", d7, 24'h100000);
        chk("long_vis", digitVisible, exp_vis(24'h100000));

        // Saturation at 999999 and recovery through clearScore
        do_clear();
        run(9999, 98);
        snap();
        chk("pre_sat_score", disp, 24'h999998);
        chk("pre_sat_flag", saturated, 0);
        run(0, 1);
        snap();
        chk("sat_tick1", disp, 24'h999999);
        run(0, 1);
        chk("sat_flag", saturated, 1);
        snap();
        chk("sat_tick2", disp, 24'h999999);
        run(0, 1);
        snap();
        chk("sat_tick3_ignored", disp, 24'h999999);
        chk("sat_still", saturated, 1);
        chk("sat_no_ovf", pendOverflow, 0);
        clearScore = 1'b1; step(); clearScore = 1'b0;
        chk("clr_digits", disp, 24'h000000);
        chk("clr_flags", {saturated, pendOverflow, busy}, 0);
        chk("clr_vis", digitVisible, exp_vis(24'h000000));
        run(0, 1);
        snap();
        chk("clr_counts_again", disp, 24'h000001);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
